// File: rtl/opcode_fetch_buffer_pkg.sv
// Shared definitions for the opcode fetch buffer: the NOP code, the fetch states and
// the 2-byte opcode decode (the assembler-side checks use the same decode).
package opcode_fetch_buffer_pkg;

    localparam logic [7:0] NOP = 8'h00;

    typedef enum logic {
        S_OP = 1'b0,
        S_OD = 1'b1
    } state_t;

    // Opcodes that carry an operand byte; everything else, incl. F0-FF port ops, is 1 byte.
    function automatic logic is_two_byte(input logic [7:0] op);
        logic r;
        r = 1'b0;
        case (op[7:3])
            5'b00001, 5'b00110, 5'b01011, 5'b10001, 5'b10011,
            5'b10101, 5'b10111, 5'b11001, 5'b11011, 5'b11101: r = 1'b1;
            5'b00000: r = (op[2:0] == 3'd3) || (op[2:0] == 3'd5);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/opcode_fetch_buffer.sv
// Fetch / opcode-buffer stage: assembles 1- or 2-byte instructions from synchronous
// program memory and hands opcode/od/bubble to stage 2, honouring hold and redirects.
module opcode_fetch_buffer
    import opcode_fetch_buffer_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              lpc,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_data,
    output logic [7:0]        opcode,
    output logic [7:0]        od,
    output logic              bb,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] next_pc
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_lat_op;
    logic [ADDR_W-1:0] r_lat_pc;
    logic [7:0]        r_opcode;
    logic [7:0]        r_od;
    logic              r_bb;
    logic [ADDR_W-1:0] r_pc_out;
    logic [ADDR_W-1:0] r_next_pc;

    state_t            w_state_next;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [7:0]        w_lat_op_next;
    logic [ADDR_W-1:0] w_lat_pc_next;
    logic [7:0]        w_opcode_next;
    logic [7:0]        w_od_next;
    logic              w_bb_next;
    logic [ADDR_W-1:0] w_pc_out_next;
    logic [ADDR_W-1:0] w_next_pc_next;

    assign w_pc_inc = r_pc + PC_ONE;

    // Next-state and next-output selection: lpc beats hold, hold freezes everything.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_lat_op_next  = r_lat_op;
        w_lat_pc_next  = r_lat_pc;
        w_opcode_next  = r_opcode;
        w_od_next      = r_od;
        w_bb_next      = r_bb;
        w_pc_out_next  = r_pc_out;
        w_next_pc_next = r_next_pc;
        if (lpc) begin
            w_state_next  = S_OP;
            w_pc_next     = pc_in;
            w_lat_op_next = NOP;
            w_opcode_next = NOP;
            w_od_next     = NOP;
            w_bb_next     = 1'b1;
        end else if (hold) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = w_pc_inc;
            case (r_state)
                S_OP: begin
                    if (is_two_byte(imem_data)) begin
                        w_state_next  = S_OD;
                        w_lat_op_next = imem_data;
                        w_lat_pc_next = r_pc;
                        w_opcode_next = NOP;
                        w_od_next     = NOP;
                        w_bb_next     = 1'b1;
                    end else begin
                        w_state_next   = S_OP;
                        w_opcode_next  = imem_data;
                        w_od_next      = NOP;
                        w_bb_next      = 1'b0;
                        w_pc_out_next  = r_pc;
                        w_next_pc_next = w_pc_inc;
                    end
                end
                S_OD: begin
                    w_state_next   = S_OP;
                    w_opcode_next  = r_lat_op;
                    w_od_next      = imem_data;
                    w_bb_next      = 1'b0;
                    w_pc_out_next  = r_lat_pc;
                    w_next_pc_next = w_pc_inc;
                end
                default: begin
                    w_state_next  = S_OP;
                    w_opcode_next = NOP;
                    w_od_next     = NOP;
                    w_bb_next     = 1'b1;
                end
            endcase
        end
    end

    // The address issued now is the pc of the byte seen next cycle.
    assign imem_addr = rst ? RESET_PC : w_pc_next;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_OP;
            r_pc      <= RESET_PC;
            r_lat_op  <= NOP;
            r_lat_pc  <= RESET_PC;
            r_opcode  <= NOP;
            r_od      <= NOP;
            r_bb      <= 1'b1;
            r_pc_out  <= RESET_PC;
            r_next_pc <= RESET_PC;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_lat_op  <= w_lat_op_next;
            r_lat_pc  <= w_lat_pc_next;
            r_opcode  <= w_opcode_next;
            r_od      <= w_od_next;
            r_bb      <= w_bb_next;
            r_pc_out  <= w_pc_out_next;
            r_next_pc <= w_next_pc_next;
        end
    end

    assign opcode  = r_opcode;
    assign od      = r_od;
    assign bb      = r_bb;
    assign pc_out  = r_pc_out;
    assign next_pc = r_next_pc;

endmodule
